// File: rtl/updown_press_ctrl_pkg.sv
// Shared encodings for the up/down press controller: FSM states, counter
// saturation limits and button-direction codes.
package updown_press_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_e;

    localparam logic [3:0] LEVEL_MAX = 4'd15;
    localparam logic [3:0] LEVEL_MIN = 4'd0;

    localparam logic DIR_PLUS  = 1'b0;
    localparam logic DIR_MINUS = 1'b1;

endpackage

// File: rtl/updown_press_ctrl_timer.sv
// press_timer: 8-bit up-counter with synchronous clear and a terminal compare
// that switches between the hold delay and the repeat period.
module press_timer #(
    parameter int HOLD_CYC = 50,
    parameter int RPT_CYC  = 10
) (
    input  logic clk_100hz,
    input  logic rst,
    input  logic clr_i,
    input  logic sel_rpt_i,
    output logic done_o
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RPT_LAST  = 8'(RPT_CYC - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The owner clears on every terminal match, so the count stops at the
    // active compare value and never wraps.
    assign cnt_d  = clr_i ? 8'd0 : cnt_q + 8'd1;
    assign done_o = (cnt_q == (sel_rpt_i ? RPT_LAST : HOLD_LAST));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_press_ctrl.sv
// Converts debounced plus/minus levels into single-cycle step pulses with
// hold-to-repeat, simultaneous-press lockout and saturation masking.
module updown_press_ctrl
    import updown_press_ctrl_pkg::*;
#(
    parameter int HOLD_CYC = 50,
    parameter int RPT_CYC  = 10
) (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic       plus_level,
    input  logic       minus_level,
    input  logic [3:0] level,
    output logic       plus_processed,
    output logic       minus_processed,
    output logic       busy
);

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   plus_q, plus_d;
    logic   minus_q, minus_d;
    logic   busy_q, busy_d;

    logic   fire;
    logic   active_level;
    logic   other_level;
    logic   timing;
    logic   done;

    assign active_level = (dir_q == DIR_MINUS) ? minus_level : plus_level;
    assign other_level  = (dir_q == DIR_MINUS) ? plus_level  : minus_level;
    assign timing       = (state_q == S_HOLD) || (state_q == S_REPEAT);

    press_timer #(
        .HOLD_CYC (HOLD_CYC),
        .RPT_CYC  (RPT_CYC)
    ) u_timer (
        .clk_100hz (clk_100hz),
        .rst       (rst),
        .clr_i     (!timing || done),
        .sel_rpt_i (state_q == S_REPEAT),
        .done_o    (done)
    );

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (plus_level && minus_level) begin
                    state_d = S_LOCK;
                end else if (plus_level) begin
                    dir_d   = DIR_PLUS;
                    state_d = S_HOLD;
                    fire    = 1'b1;
                end else if (minus_level) begin
                    dir_d   = DIR_MINUS;
                    state_d = S_HOLD;
                    fire    = 1'b1;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!active_level) begin
                    state_d = S_IDLE;
                end else if (other_level) begin
                    state_d = S_LOCK;
                end else if (done) begin
                    state_d = S_REPEAT;
                    fire    = 1'b1;
                end
            end
            S_LOCK: begin
                if (!plus_level && !minus_level) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Suppress the step the counter would saturate on; the FSM advances anyway.
    assign plus_d  = fire && (dir_d == DIR_PLUS)  && (level != LEVEL_MAX);
    assign minus_d = fire && (dir_d == DIR_MINUS) && (level != LEVEL_MIN);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_PLUS;
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            plus_q  <= plus_d;
            minus_q <= minus_d;
            busy_q  <= busy_d;
        end
    end

    assign plus_processed  = plus_q;
    assign minus_processed = minus_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_updown_press_ctrl.sv
// Self-checking bench for updown_press_ctrl: directed scenarios plus random
// button traffic, compared every cycle against a press-age reference model.
module tb_updown_press_ctrl;

    localparam int HOLD = 50;
    localparam int RPT  = 10;

    logic       clk_100hz = 1'b0;
    logic       rst = 1'b0;
    logic       plus_level = 1'b0;
    logic       minus_level = 1'b0;
    logic [3:0] level = 4'd7;
    logic       plus_processed;
    logic       minus_processed;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int plus_total = 0;
    int minus_total = 0;

    // Reference model: mode 0 = idle, 1 = a button is being tracked, 2 = locked.
    int   m_mode = 0;
    int   m_dir = 0;
    int   m_age = 0;
    logic e_plus = 1'b0;
    logic e_minus = 1'b0;
    logic e_busy = 1'b0;

    updown_press_ctrl #(
        .HOLD_CYC (HOLD),
        .RPT_CYC  (RPT)
    ) dut (
        .clk_100hz       (clk_100hz),
        .rst             (rst),
        .plus_level      (plus_level),
        .minus_level     (minus_level),
        .level           (level),
        .plus_processed  (plus_processed),
        .minus_processed (minus_processed),
        .busy            (busy)
    );

    always #5 clk_100hz = ~clk_100hz;

    initial begin
        forever begin
            @(posedge clk_100hz or negedge rst);
            if (!rst) begin
                m_mode = 0; m_dir = 0; m_age = 0;
                e_plus = 1'b0; e_minus = 1'b0; e_busy = 1'b0;
            end else begin
                bit fire;
                bit act;
                bit oth;
                fire = 1'b0;
                act  = (m_dir == 1) ? minus_level : plus_level;
                oth  = (m_dir == 1) ? plus_level  : minus_level;
                if (m_mode == 0) begin
                    if (plus_level && minus_level) begin
                        m_mode = 2;
                    end else if (plus_level || minus_level) begin
                        m_mode = 1; m_dir = minus_level ? 1 : 0; m_age = 0; fire = 1'b1;
                    end
                end else if (m_mode == 1) begin
                    if (!act) m_mode = 0;
                    else if (oth) m_mode = 2;
                    else begin
                        m_age++;
                        if (m_age >= HOLD && ((m_age - HOLD) % RPT) == 0) fire = 1'b1;
                    end
                end else if (!plus_level && !minus_level) begin
                    m_mode = 0;
                end
                e_plus  = fire && (m_dir == 0) && (level != 4'd15);
                e_minus = fire && (m_dir == 1) && (level != 4'd0);
                e_busy  = (m_mode != 0);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive levels for n cycles; outputs are compared 1 time unit after each edge.
    task automatic step(input logic p, input logic m, input logic [3:0] lvl, input int n);
        for (int i = 0; i < n; i++) begin
            plus_level  = p;
            minus_level = m;
            level       = lvl;
            @(posedge clk_100hz);
            #1;
            check("plus_processed", int'(plus_processed), int'(e_plus));
            check("minus_processed", int'(minus_processed), int'(e_minus));
            check("busy", int'(busy), int'(e_busy));
            if (plus_processed && minus_processed)
                check("pulse_exclusive", 1, 0);
            if (plus_processed) plus_total++;
            if (minus_processed) minus_total++;
            #1;
        end
    endtask

    initial begin
        int p0;
        int m0;

        #1;
        check("reset_plus", int'(plus_processed), 0);
        check("reset_minus", int'(minus_processed), 0);
        check("reset_busy", int'(busy), 0);
        step(0, 0, 7, 2);
        rst = 1'b1;
        step(0, 0, 7, 3);

        // Tap: one pulse one edge after the first sampled high
        p0 = plus_total; m0 = minus_total;
        step(1, 0, 4, 1);
        check("tap_first_pulse", int'(plus_processed), 1);
        step(1, 0, 4, 2);
        check("tap_busy_held", int'(busy), 1);
        step(0, 0, 4, 1);
        check("tap_busy_release", int'(busy), 0);
        step(0, 0, 4, 3);
        check("tap_pulse_count", plus_total - p0, 1);
        check("tap_minus_count", minus_total - m0, 0);

        // Hold minus 100 cycles: pulses at offsets 0,50,60,70,80,90
        m0 = minus_total;
        step(0, 1, 15, 100);
        step(0, 0, 15, 5);
        check("hold_minus_count", minus_total - m0, 6);

        // Plus held at saturation: no pulses but the FSM keeps running
        p0 = plus_total;
        step(1, 0, 15, 100);
        check("sat_busy", int'(busy), 1);
        step(0, 0, 15, 3);
        check("sat_plus_count", plus_total - p0, 0);

        // Simultaneous rise locks out until both released
        p0 = plus_total; m0 = minus_total;
        step(1, 1, 7, 5);
        check("sim_lock_busy", int'(busy), 1);
        step(0, 1, 7, 5);
        check("sim_partial_busy", int'(busy), 1);
        step(0, 0, 7, 1);
        check("sim_release_idle", int'(busy), 0);
        check("sim_pulse_count", (plus_total - p0) + (minus_total - m0), 0);

        // Second button during a plus hold
        p0 = plus_total; m0 = minus_total;
        step(1, 0, 7, 20);
        step(1, 1, 7, 40);
        step(1, 0, 7, 20);
        check("second_lock_busy", int'(busy), 1);
        step(0, 0, 7, 3);
        check("second_plus_count", plus_total - p0, 1);
        check("second_minus_count", minus_total - m0, 0);

        // Reset mid-repeat, then re-press on the first sampled edge
        step(1, 0, 7, 55);
        rst = 1'b0;
        #1;
        check("rst_mid_plus", int'(plus_processed), 0);
        check("rst_mid_busy", int'(busy), 0);
        #1;
        step(1, 0, 7, 3);
        rst = 1'b1;
        step(1, 0, 7, 1);
        check("rst_repress_pulse", int'(plus_processed), 1);
        step(0, 0, 7, 3);

        // Random traffic
        for (int b = 0; b < 220; b++) begin
            logic       p;
            logic       m;
            logic [3:0] lv;
            int         r;
            r  = $urandom_range(0, 9);
            p  = (r < 4) || (r == 8);
            m  = ((r >= 4) && (r < 8)) || (r == 8);
            r  = $urandom_range(0, 3);
            lv = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                step(p, m, lv, $urandom_range(1, 3));
                rst = 1'b1;
            end
            step(p, m, lv, $urandom_range(1, 80));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_press_ctrl.md
# updown_press_ctrl

Press controller that sits between the debounced plus/minus push-button levels and the 4-bit saturating up/down level counter. It converts held buttons into single-cycle `plus_processed` / `minus_processed` step pulses with hold-to-repeat. It arbitrates simultaneous presses by locking out until both buttons are released. It suppresses pulses that the counter would saturate on, using the counter's current value fed back as `level`.

## Interface
- `HOLD_CYC`, 50: cycles from the first pulse to the first repeat pulse (0.5 s at 100 Hz); legal 2..255
- `RPT_CYC`, 10: cycles between repeat pulses (0.1 s at 100 Hz); legal 2..255

- `clk_100hz` input 1: sole clock, all state updates on the rising edge
- `rst` input 1: reset, asynchronous, active-low
- `plus_level` input 1: debounced plus button level, synchronous to `clk_100hz`
- `minus_level` input 1: debounced minus button level, synchronous to `clk_100hz`
- `level` input 4: current counter value (feedback)
- `plus_processed` output 1: registered one-cycle increment request
- `minus_processed` output 1: registered one-cycle decrement request
- `busy` output 1: registered, high whenever the FSM is not in IDLE

## Operation
- FSM states are IDLE, HOLD, REPEAT and LOCK.
- `dir` register holds the active button (0 = plus, 1 = minus). An 8-bit `cnt` register holds the timer.
- **IDLE**
  - Both levels high: go to LOCK, no pulse.
  - Only plus high: `dir`=0, `cnt`=0, go to HOLD, issue a plus pulse.
  - Only minus high: `dir`=1, `cnt`=0, go to HOLD, issue a minus pulse.
  - Neither high: stay in IDLE.
- **HOLD** (checks in priority order)
  1. Active button low: go to IDLE. This applies even if the other button is high in the same cycle; the other press is seen on the next cycle from IDLE.
  2. Other button high: go to LOCK.
  3. `cnt`==HOLD_CYC-1: go to REPEAT, `cnt`=0, issue a pulse.
  4. Otherwise: `cnt`+1.
- **REPEAT**: same priority as HOLD, using RPT_CYC-1 as the compare value. On a match, stay in REPEAT, `cnt`=0, issue a pulse.
- **LOCK**: stay until both levels are low, then go to IDLE. No pulses are issued.
- **Saturation mask**: "issue a pulse" asserts the output selected by `dir`, except:
  - no plus pulse when `level`==4'd15;
  - no minus pulse when `level`==4'd0.
  - Timing and state transitions continue unchanged while masked.
- `plus_processed` and `minus_processed` are never high in the same cycle.
- `cnt` never exceeds max(HOLD_CYC, RPT_CYC)-1. There is no wrap-around.

## Timing
- **Reset** (`rst`=0, asynchronous): state=IDLE, `dir`=0, `cnt`=0, `plus_processed`=0, `minus_processed`=0, `busy`=0. Reset mid-hold or mid-repeat aborts immediately with no trailing pulse.
- **First pulse**: the press is first sampled high at edge N. The pulse is high from edge N to edge N+1, a latency of 1 cycle from the sampled level.
- **Repeat pulses**: the first repeat pulse is at edge N+HOLD_CYC. Later pulses are at N+HOLD_CYC+k·RPT_CYC for k≥1.
- **Release**: the active button is sampled low at edge M. No pulse is issued at or after edge M.
- **Pulse width**: every pulse is exactly one cycle wide. Back-to-back pulses are impossible because RPT_CYC≥2.
- **Saturation**: `level` is sampled on the same edge that would issue the pulse. The counter updates on the edge after the pulse. The mask therefore sees the updated value on the next pulse opportunity, at least 2 cycles later.

## Structure
- Shared package holds:
  - state encoding localparams: S_IDLE=2'd0, S_HOLD=2'd1, S_REPEAT=2'd2, S_LOCK=2'd3;
  - LEVEL_MAX=4'd15 and LEVEL_MIN=4'd0;
  - DIR_PLUS=1'b0 and DIR_MINUS=1'b1.
- One sub-module, `press_timer`:
  - 8-bit counter with synchronous clear;
  - runtime-selectable terminal compare (HOLD_CYC-1 or RPT_CYC-1);
  - `done` output.
- The top-level FSM, the saturation mask and the output registers live in `updown_press_ctrl`.

## Test plan
All scenarios use HOLD_CYC=50 and RPT_CYC=10.
- Tap: plus high for 3 cycles with `level`=4 → exactly one `plus_processed` pulse, 1 cycle after the first sampled high; `busy` returns to 0 one cycle after release.
- Hold: minus held for 100 cycles with `level`=15 → minus pulses at edges N, N+50, N+60, N+70, N+80, N+90, giving 6 pulses; none after release.
- Saturation: plus held for 100 cycles with `level` tied at 15 → zero pulses; FSM still reaches REPEAT (`busy`=1).
- Simultaneous: plus and minus rise on the same cycle → LOCK, no pulses; release only plus → still no pulses; release minus → IDLE next cycle.
- Second button while holding: hold plus, then raise minus at cycle 20 → LOCK, no further pulses until both are low.
- Reset mid-repeat: assert `rst`=0 at cycle 55 of a plus hold → outputs 0 immediately; after deassertion with plus still high → new first pulse on the first sampled edge.
